// File: rtl/minhash_selector_pkg.sv
// Shared constants and types for the hasher -> minhash selector -> extender path.
// Slot and state types used by the bottom-k selector.
package minhash_selector_pkg;

   localparam int BASE_LEN               = 4;
   localparam int KMER_LEN               = 4;
   localparam int HASHER_KMER_LEN        = KMER_LEN;
   localparam int EXTENDER_ACTUAL_MEM    = 32;
   localparam int EXTENDER_INDICES_COUNT = 2;
   localparam int EXTENDER_INDICE_LEN    = 5;

   localparam int MINSEL_HASH_LEN   = KMER_LEN * BASE_LEN;
   localparam int MINSEL_KMER_COUNT = EXTENDER_ACTUAL_MEM - KMER_LEN + 1;

   typedef enum logic {
      MINSEL_COLLECT,
      MINSEL_EMIT
   } minsel_state_t;

   typedef struct packed {
      logic                           vld;
      logic [MINSEL_HASH_LEN-1:0]     hash;
      logic [EXTENDER_INDICE_LEN-1:0] idx;
   } minsel_slot_t;

endpackage

// File: rtl/minhash_selector_insert.sv
// Combinational sorted insert of one {hash, pos} into a K-slot bottom-k list.
// Slot 0 holds the smallest hash; packed vectors keep slot 0 in the low bits.
module bottomk_insert #(
   parameter int K        = 2,
   parameter int HASH_LEN = 16,
   parameter int IDX_LEN  = 5
) (
   input  logic [K-1:0]          vld_i,
   input  logic [K*HASH_LEN-1:0] hash_i,
   input  logic [K*IDX_LEN-1:0]  idx_i,
   input  logic [HASH_LEN-1:0]   h_i,
   input  logic [IDX_LEN-1:0]    p_i,
   output logic [K-1:0]          vld_o,
   output logic [K*HASH_LEN-1:0] hash_o,
   output logic [K*IDX_LEN-1:0]  idx_o
);

   logic [K-1:0]          vld_sh;
   logic [K*HASH_LEN-1:0] hash_sh;
   logic [K*IDX_LEN-1:0]  idx_sh;

   // Slot j-1 viewed at position j: the "shift down" source.
   assign vld_sh  = vld_i << 1;
   assign hash_sh = hash_i << HASH_LEN;
   assign idx_sh  = idx_i << IDX_LEN;

   always_comb begin
      logic found;
      logic hit;
      found  = 1'b0;
      hit    = 1'b0;
      vld_o  = vld_i;
      hash_o = hash_i;
      idx_o  = idx_i;
      for (int j = 0; j < K; j++) begin
         // Strict less-than keeps the earlier position on ties.
         hit = !vld_i[j] ||
               (h_i < hash_i[j*HASH_LEN +: HASH_LEN]);
         if (found) begin
            vld_o[j]                   = vld_sh[j];
            hash_o[j*HASH_LEN +: HASH_LEN] =
               hash_sh[j*HASH_LEN +: HASH_LEN];
            idx_o[j*IDX_LEN +: IDX_LEN] =
               idx_sh[j*IDX_LEN +: IDX_LEN];
         end else if (hit) begin
            vld_o[j]                       = 1'b1;
            hash_o[j*HASH_LEN +: HASH_LEN] = h_i;
            idx_o[j*IDX_LEN +: IDX_LEN]    = p_i;
         end
         found = found | hit;
      end
   end

endmodule

// File: rtl/minhash_selector.sv
// Streaming bottom-k selector: keeps the K smallest hashes of each window
// and hands their positions to the extender over a valid/ready handshake.
module minhash_selector
   import minhash_selector_pkg::*;
#(
   parameter int HASH_LEN   = MINSEL_HASH_LEN,
   parameter int ACTUAL_MEM = EXTENDER_ACTUAL_MEM,
   parameter int KMER       = HASHER_KMER_LEN,
   parameter int K          = EXTENDER_INDICES_COUNT,
   parameter int IDX_LEN    = EXTENDER_INDICE_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [HASH_LEN-1:0]   in_hash,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [K*IDX_LEN-1:0]  out_indices,
   output logic [K*HASH_LEN-1:0] out_hashes
);

   localparam int NKMER = ACTUAL_MEM - KMER + 1;
   localparam logic [IDX_LEN-1:0] LAST = IDX_LEN'(NKMER - 1);

   if (NKMER - 1 > 2**IDX_LEN - 1) begin : g_idx_chk
      $error("IDX_LEN too narrow for NKMER positions");
   end
   if (NKMER < K) begin : g_k_chk
      $error("window shorter than K");
   end

   minsel_state_t         state_q, state_d;
   logic [IDX_LEN-1:0]    pos_q, pos_d;
   logic [K-1:0]          vld_q, vld_d, vld_ins;
   logic [K*HASH_LEN-1:0] hash_q, hash_d, hash_ins;
   logic [K*IDX_LEN-1:0]  idx_q, idx_d, idx_ins;

   bottomk_insert #(
      .K        (K),
      .HASH_LEN (HASH_LEN),
      .IDX_LEN  (IDX_LEN)
   ) u_insert (
      .vld_i  (vld_q),
      .hash_i (hash_q),
      .idx_i  (idx_q),
      .h_i    (in_hash),
      .p_i    (pos_q),
      .vld_o  (vld_ins),
      .hash_o (hash_ins),
      .idx_o  (idx_ins)
   );

   assign in_ready    = !rst && (state_q == MINSEL_COLLECT);
   assign out_valid   = (state_q == MINSEL_EMIT);
   assign out_indices = idx_q;
   assign out_hashes  = hash_q;

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      vld_d   = vld_q;
      hash_d  = hash_q;
      idx_d   = idx_q;
      unique case (state_q)
         MINSEL_COLLECT: begin
            if (in_valid && in_ready) begin
               vld_d  = vld_ins;
               hash_d = hash_ins;
               idx_d  = idx_ins;
               if (pos_q == LAST) begin
                  pos_d   = '0;
                  state_d = MINSEL_EMIT;
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
         end
         MINSEL_EMIT: begin
            // Slot contents stay visible; only validity is cleared.
            if (out_ready) begin
               vld_d   = '0;
               state_d = MINSEL_COLLECT;
            end
         end
         default: state_d = MINSEL_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MINSEL_COLLECT;
         pos_q   <= '0;
         vld_q   <= '0;
         hash_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         vld_q   <= vld_d;
         hash_q  <= hash_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: doc/minhash_selector.md
# minhash_selector

Streaming bottom-k selector between the hasher and the extender. It accepts one k-mer hash per cycle from the hasher. For each fixed window of k-mer positions in a fragment memory line, it keeps the EXTENDER_INDICES_COUNT smallest hashes and the start positions where they occur. At window end it presents the sorted positions (and their hashes) to the extender through a valid/ready handshake.

## Interface
Parameters:
- HASH_LEN, default KMER_LEN*BASE_LEN (16): hash width in bits.
- ACTUAL_MEM, default EXTENDER_ACTUAL_MEM (32): bases per window.
- KMER, default HASHER_KMER_LEN (4): k-mer length in bases.
- K, default EXTENDER_INDICES_COUNT (2): number of minima kept.
- IDX_LEN, default EXTENDER_INDICE_LEN (5): position index width.
- Derived, not overridable: NKMER = ACTUAL_MEM-KMER+1 (29) hashes per window.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: the hasher presents in_hash.
- in_ready, out, 1: the selector accepts the hash this cycle.
- in_hash, in, HASH_LEN: hash of the k-mer at the current position.
- out_valid, out, 1: the result is available.
- out_ready, in, 1: the extender consumes the result.
- out_indices, out, K*IDX_LEN: slot 0 (smallest hash) is in the low bits.
- out_hashes, out, K*HASH_LEN: hashes matching out_indices, same ordering.

## Operation
- The state machine has two states, COLLECT and EMIT.
- COLLECT:
  - in_ready=1.
  - Each accept (in_valid&&in_ready) is assigned position pos, which runs 0..NKMER-1.
  - The accepted hash is inserted into a sorted K-slot list. Each slot holds a hash, an index and a valid bit.
- Insertion rule, for new hash h at position p:
  - Find the first slot i such that slot i is invalid or h < hash[i], using strict less-than.
  - Slots i..K-2 shift down one; slot K-1 is dropped.
  - Slot i takes {h, p, valid}.
  - If no such slot exists, the list is unchanged.
- Ties keep the earlier position. A hash of all-ones is still inserted into an invalid slot; the valid bits, not a sentinel value, decide emptiness.
- The accept at pos==NKMER-1 performs its insertion. The state then moves to EMIT and pos returns to 0.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_indices and out_hashes are driven from the slots and hold stable until out_ready.
  - When out_valid&&out_ready: all slot valid bits clear and the state returns to COLLECT.
- Because NKMER≥K, every emitted result has all K slots valid.
- Reset establishes:
  - state=COLLECT, pos=0.
  - All slots invalid, with hash and index fields set to 0.
  - out_valid=0, out_indices=0, out_hashes=0.
  - in_ready=0 while rst is high, then 1.
- Reset asserted mid-window discards the partial window. Counting restarts at position 0.
- Reset during EMIT drops the pending result without it being consumed.

## Timing
- Throughput: one hash per cycle in COLLECT.
- There is a minimum one-cycle bubble per window: EMIT with out_ready already high.
- Latency: out_valid rises in the cycle after the accept of the last hash.
- out_* are registered.
- in_ready is a function of state and rst only. It does not depend on in_valid or out_ready, so there is no combinational input-to-output path.
- Insertion is a single-cycle compare of h against all K slots in parallel, followed by the shift.
- pos needs IDX_LEN bits. NKMER-1 ≤ 2^IDX_LEN-1 is required, checked by an elaboration assertion.
- in_valid low in COLLECT stalls the window. pos and the slots hold.
- In EMIT, in_valid high is ignored and no hash is lost: the hasher holds its hash because in_ready=0.

## Structure
Add to proj_pkg:
- MINSEL_HASH_LEN = KMER_LEN*BASE_LEN.
- MINSEL_KMER_COUNT = EXTENDER_ACTUAL_MEM-KMER_LEN+1.
- typedef enum logic {MINSEL_COLLECT, MINSEL_EMIT} minsel_state_t.
- typedef struct packed {logic vld; logic [MINSEL_HASH_LEN-1:0] hash; logic [EXTENDER_INDICE_LEN-1:0] idx;} minsel_slot_t.

Sub-module:
- bottomk_insert, a combinational block.
- Inputs: the slot array and {h, p}.
- Output: the next slot array.
- It is instantiated once. minhash_selector owns the FSM, the pos counter and the registers.

## Test plan
- Descending stream, in_hash = 28-pos for pos 0..28, out_ready=1.
  - Response: out_indices={28,27}, out_hashes={0,1}.
  - out_valid rises 1 cycle after pos 28 and is high for 1 cycle.
- Ascending stream, in_hash = 100+pos.
  - Response: indices {0,1}, hashes {100,101}.
- All hashes 0x1234, and separately all 0xFFFF.
  - Response in both cases: indices {0,1}. This checks tie-keeps-earliest and valid-bit handling.
- Hash 5 at pos 3 and 17, 9 at pos 20, all others 0x8000.
  - Response: indices {3,17}, hashes {5,5}.
- Backpressure: out_ready=0 for 6 cycles in EMIT with in_valid held 1.
  - Response: in_ready=0, outputs stable, no accepts.
  - Then out_ready=1, followed by the next descending window.
  - Required: correct {28,27} result and no hash dropped.
- Reset: assert rst for 1 cycle after 10 accepts, then send a full ascending window.
  - Response: outputs 0 during reset; result indices {0,1} relative to post-reset counting.
  - Out-of-window random gaps on in_valid are also checked against a reference model: results must match.
